axis_fifo_lvl: RTL and testbench

- Synchronous AXI-stream FIFO with registered first-word-fall-through output.
- Adds over the previous generation: tlast sideband, occupancy count, and programmable almost-full/almost-empty flags.
- Optional packet mode withholds output until a whole frame is stored.
- Sits between the ADC sample framer and the DSP/DMA stages, which use the level flags for backpressure and burst scheduling.

---
 rtl/axis_fifo_lvl.sv | 187 ++++++++++++++++++
 tb/tb_axis_fifo_lvl.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_fifo_lvl.sv
// axis_fifo_lvl: synchronous AXI-stream FIFO with a registered
// first-word-fall-through output, tlast sideband, occupancy count and
// programmable almost-full / almost-empty flags.
//
// Capacity is FIFO_DEPTH words in total: FIFO_DEPTH-1 in the memory plus one
// in the output register. A word written into an empty FIFO bypasses the
// memory and is presented on the very next cycle.
//
// Optional build macro AXIS_FIFO_PKT_MODE_EN: output is withheld until at
// least one complete frame (a word carrying tlast) is stored. A FIFO filled
// to capacity without any tlast releases its contents anyway, and keeps
// releasing until that oversize frame's tlast is read, so a frame larger
// than the FIFO cannot deadlock the stream.
//
// ena low freezes every register; s_axis_tready and m_axis_tvalid are forced
// low for that cycle and m_axis_tvalid returns with the same word once ena
// rises again.

module axis_fifo_lvl #(
  parameter int DATA_WIDTH   = 8,
  parameter int FIFO_DEPTH   = 16,
  parameter int AFULL_LEVEL  = 12,
  parameter int AEMPTY_LEVEL = 2,
  localparam int LW          = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ena,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tlast,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tlast,
  output logic [LW-1:0]         fill_level,
  output logic                  almost_full,
  output logic                  almost_empty
);

  localparam int MEM_DEPTH = FIFO_DEPTH - 1;
  localparam int PW        = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int EW        = DATA_WIDTH + 1;

  localparam logic [LW-1:0] LVL_FULL   = LW'(FIFO_DEPTH);
  localparam logic [LW-1:0] LVL_AFULL  = LW'(AFULL_LEVEL);
  localparam logic [LW-1:0] LVL_AEMPTY = LW'(AEMPTY_LEVEL);
  localparam logic [PW-1:0] PTR_LAST   = PW'(MEM_DEPTH - 1);

  // {tlast, tdata} storage behind the output register
  logic [EW-1:0] mem [MEM_DEPTH];

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          out_full;     // output register holds an undelivered word
  logic [LW-1:0] mem_count;    // words held in memory only
  logic [LW-1:0] fill_next;

  logic wr_en;
  logic rd_en;
  logic out_free;
  logic mem_empty;
  logic bypass;
  logic mem_wr;
  logic mem_rd;
  logic out_load;
  logic release_ok;            // output may be presented downstream

  // Pointer advance with wrap at the last memory entry, any depth.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PW'(1);
  endfunction

`ifdef AXIS_FIFO_PKT_MODE_EN
  logic [LW-1:0] frame_count;      // tlast-terminated frames currently stored
  logic          oversize_release; // full without tlast: let the frame drain

  assign release_ok = (frame_count != '0) | oversize_release |
                      (fill_level == LVL_FULL);
`else
  assign release_ok = 1'b1;
`endif

  // A word in the output register is always older than anything in memory,
  // and the output register is refilled before memory can hold data, so the
  // memory share of the level is simply the level minus that register.
  assign mem_count = fill_level - {{(LW-1){1'b0}}, out_full};
  assign mem_empty = (mem_count == '0);

  assign s_axis_tready = ena & ~rst & (fill_level < LVL_FULL);
  assign m_axis_tvalid = ena & ~rst & out_full & release_ok;

  assign wr_en    = s_axis_tvalid & s_axis_tready;
  assign rd_en    = m_axis_tvalid & m_axis_tready;
  assign out_free = ena & (~out_full | rd_en);
  assign bypass   = wr_en & mem_empty & out_free;
  assign mem_wr   = wr_en & ~bypass;
  assign mem_rd   = out_free & ~mem_empty;
  assign out_load = mem_rd | bypass;

  // Next occupancy: +1 on write only, -1 on read only, else unchanged.
  always_comb begin
    fill_next = fill_level;
    case ({wr_en, rd_en})
      2'b10:   fill_next = fill_level + LW'(1);
      2'b01:   fill_next = fill_level - LW'(1);
      default: fill_next = fill_level;
    endcase
  end

  // Memory write port; contents need no reset.
  always_ff @(posedge clk) begin
    if (mem_wr) begin
      mem[wr_ptr] <= {s_axis_tlast, s_axis_tdata};
    end
  end

  // Read and write pointers into the memory.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (ena) begin
      if (mem_wr) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (mem_rd) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
    end
  end

  // Output register: refilled from memory, or straight from the input when
  // memory is empty, whenever it is empty or being read.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_full     <= 1'b0;
      m_axis_tdata <= '0;
      m_axis_tlast <= 1'b0;
    end else if (ena) begin
      if (out_load) begin
        out_full <= 1'b1;
        {m_axis_tlast, m_axis_tdata} <= mem_rd ? mem[rd_ptr]
                                               : {s_axis_tlast, s_axis_tdata};
      end else if (rd_en) begin
        out_full <= 1'b0;
      end
    end
  end

  // Occupancy and level flags, all derived from the same next value so they
  // change on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      fill_level   <= '0;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
    end else if (ena) begin
      fill_level   <= fill_next;
      almost_full  <= (fill_next >= LVL_AFULL);
      almost_empty <= (fill_next <= LVL_AEMPTY);
    end
  end

`ifdef AXIS_FIFO_PKT_MODE_EN
  // Stored-frame count and the oversize-frame release latch.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_count      <= '0;
      oversize_release <= 1'b0;
    end else if (ena) begin
      case ({wr_en & s_axis_tlast, rd_en & m_axis_tlast})
        2'b10:   frame_count <= frame_count + LW'(1);
        2'b01:   frame_count <= frame_count - LW'(1);
        default: frame_count <= frame_count;
      endcase
      if (rd_en & m_axis_tlast) begin
        oversize_release <= 1'b0;
      end else if (fill_level == LVL_FULL) begin
        oversize_release <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_axis_fifo_lvl.sv
// Bench for axis_fifo_lvl: directed sequences on a depth-16 instance and a
// randomised order check on a depth-5 instance. Accepted input words are
// pushed into per-instance queues; monitors pop and compare on each output
// handshake and compare the level and flags against the queue occupancy.

module tb_axis_fifo_lvl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ena = 1'b1;

  always #5 clk = ~clk;

  // depth-16 instance
  logic       a_s_tvalid = 1'b0;
  logic       a_s_tready;
  logic [7:0] a_s_tdata = '0;
  logic       a_s_tlast = 1'b0;
  logic       a_m_tvalid;
  logic       a_m_tready = 1'b0;
  logic [7:0] a_m_tdata;
  logic       a_m_tlast;
  logic [4:0] a_fill;
  logic       a_af;
  logic       a_ae;

  // depth-5 instance
  logic       b_ena = 1'b1;
  logic       b_s_tvalid = 1'b0;
  logic       b_s_tready;
  logic [7:0] b_s_tdata = '0;
  logic       b_s_tlast = 1'b0;
  logic       b_m_tvalid;
  logic       b_m_tready = 1'b0;
  logic [7:0] b_m_tdata;
  logic       b_m_tlast;
  logic [3:0] b_fill;
  logic       b_af;
  logic       b_ae;

  axis_fifo_lvl #(.DATA_WIDTH(8), .FIFO_DEPTH(16), .AFULL_LEVEL(12), .AEMPTY_LEVEL(2)) dut_a (
    .clk(clk), .rst(rst), .ena(ena),
    .s_axis_tvalid(a_s_tvalid), .s_axis_tready(a_s_tready),
    .s_axis_tdata(a_s_tdata), .s_axis_tlast(a_s_tlast),
    .m_axis_tvalid(a_m_tvalid), .m_axis_tready(a_m_tready),
    .m_axis_tdata(a_m_tdata), .m_axis_tlast(a_m_tlast),
    .fill_level(a_fill), .almost_full(a_af), .almost_empty(a_ae)
  );

  axis_fifo_lvl #(.DATA_WIDTH(8), .FIFO_DEPTH(5), .AFULL_LEVEL(4), .AEMPTY_LEVEL(1)) dut_b (
    .clk(clk), .rst(rst), .ena(b_ena),
    .s_axis_tvalid(b_s_tvalid), .s_axis_tready(b_s_tready),
    .s_axis_tdata(b_s_tdata), .s_axis_tlast(b_s_tlast),
    .m_axis_tvalid(b_m_tvalid), .m_axis_tready(b_m_tready),
    .m_axis_tdata(b_m_tdata), .m_axis_tlast(b_m_tlast),
    .fill_level(b_fill), .almost_full(b_af), .almost_empty(b_ae)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int rcv_b  = 0;
  bit run    = 1'b0;

  logic [8:0] qa[$];
  logic [8:0] qb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // monitor for instance A
  always @(negedge clk) begin
    if (run) begin
      check("a_level",  32'(a_fill), 32'(qa.size()));
      check("a_afull",  32'(a_af),   32'(qa.size() >= 12));
      check("a_aempty", 32'(a_ae),   32'(qa.size() <= 2));
      if (rst) begin
        qa.delete();
      end else begin
        if (a_s_tvalid && a_s_tready) qa.push_back({a_s_tlast, a_s_tdata});
        if (a_m_tvalid && a_m_tready) begin
          if (qa.size() == 0) begin
            n_chk++;
            $display("FAIL a_out: got 0x%0h with nothing expected", {a_m_tlast, a_m_tdata});
          end else begin
            check("a_out", 32'({a_m_tlast, a_m_tdata}), 32'(qa.pop_front()));
          end
        end
      end
    end
  end

  // monitor for instance B
  always @(negedge clk) begin
    if (run) begin
      check("b_level",  32'(b_fill), 32'(qb.size()));
      check("b_afull",  32'(b_af),   32'(qb.size() >= 4));
      check("b_aempty", 32'(b_ae),   32'(qb.size() <= 1));
      if (rst) begin
        qb.delete();
      end else begin
        if (b_s_tvalid && b_s_tready) qb.push_back({b_s_tlast, b_s_tdata});
        if (b_m_tvalid && b_m_tready) begin
          rcv_b++;
          if (qb.size() == 0) begin
            n_chk++;
            $display("FAIL b_out: got 0x%0h with nothing expected", {b_m_tlast, b_m_tdata});
          end else begin
            check("b_out", 32'({b_m_tlast, b_m_tdata}), 32'(qb.pop_front()));
          end
        end
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1; ena = 1'b1;
    a_s_tvalid = 1'b0; a_s_tlast = 1'b0; a_m_tready = 1'b0;
    b_s_tvalid = 1'b0; b_s_tlast = 1'b0; b_m_tready = 1'b0;
    step(); step();
    check("rst_tready",  32'(a_s_tready), 32'd0);
    check("rst_tvalid",  32'(a_m_tvalid), 32'd0);
    check("rst_tdata",   32'(a_m_tdata),  32'd0);
    check("rst_tlast",   32'(a_m_tlast),  32'd0);
    check("rst_level",   32'(a_fill),     32'd0);
    check("rst_afull",   32'(a_af),       32'd0);
    check("rst_aempty",  32'(a_ae),       32'd1);
    run = 1'b1;
    rst = 1'b0;
    #1;
    check("rst_tready_after", 32'(a_s_tready), 32'd1);
    step();
  endtask

  int  t;
  int  sent;
  bit  acc;

  initial begin
    // basic write then drain
    do_reset();
    a_m_tready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      a_s_tvalid = 1'b1; a_s_tdata = 8'(8'h11 + i); a_s_tlast = (i == 3);
      step();
    end
    a_s_tvalid = 1'b0; a_s_tlast = 1'b0;
    check("t1_level",  32'(a_fill),     32'd4);
    check("t1_aempty", 32'(a_ae),       32'd0);
    check("t1_afull",  32'(a_af),       32'd0);
    check("t1_valid",  32'(a_m_tvalid), 32'd1);
    check("t1_data",   32'(a_m_tdata),  32'h11);
    step();
    check("t1_data_held", 32'(a_m_tdata), 32'h11);
    a_m_tready = 1'b1;
    repeat (4) step();
    check("t1_drained", 32'(a_fill),     32'd0);
    check("t1_novalid", 32'(a_m_tvalid), 32'd0);
    a_m_tready = 1'b0;

    // fill to capacity, then stream at full
    do_reset();
    for (int i = 0; i < 16; i++) begin
      a_s_tvalid = 1'b1; a_s_tdata = 8'(8'h20 + i); a_s_tlast = 1'b0;
      step();
      if (i == 10) check("t2_afull_at11", 32'(a_af), 32'd0);
      if (i == 11) check("t2_afull_at12", 32'(a_af), 32'd1);
    end
    a_s_tdata = 8'h30;
    check("t2_full_level",  32'(a_fill),     32'd16);
    check("t2_full_tready", 32'(a_s_tready), 32'd0);
    check("t2_full_afull",  32'(a_af),       32'd1);
    a_m_tready = 1'b1;
    for (int k = 0; k < 40; k++) begin
      acc = a_s_tvalid && a_s_tready;
      step();
      if (acc) a_s_tdata = a_s_tdata + 8'd1;
      check("t2_level_high", 32'(a_fill >= 5'd15), 32'd1);
    end
    a_s_tvalid = 1'b0;
    t = 0;
    while (a_fill != 0 && t < 40) begin step(); t++; end
    check("t2_drained", 32'(a_fill), 32'd0);
    a_m_tready = 1'b0;

    // clock enable freeze
    do_reset();
    a_s_tvalid = 1'b1; a_s_tdata = 8'hA5; a_s_tlast = 1'b1;
    step();
    a_s_tvalid = 1'b0;
    check("t4_valid", 32'(a_m_tvalid), 32'd1);
    check("t4_data",  32'(a_m_tdata),  32'hA5);
    ena = 1'b0; a_s_tvalid = 1'b1; a_s_tdata = 8'h5A; a_m_tready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("t4_off_tready", 32'(a_s_tready), 32'd0);
      check("t4_off_tvalid", 32'(a_m_tvalid), 32'd0);
      check("t4_off_level",  32'(a_fill),     32'd1);
      step();
    end
    ena = 1'b1; a_s_tvalid = 1'b0; a_s_tlast = 1'b0; a_m_tready = 1'b0;
    #1;
    check("t4_on_valid", 32'(a_m_tvalid), 32'd1);
    check("t4_on_data",  32'(a_m_tdata),  32'hA5);
    check("t4_on_level", 32'(a_fill),     32'd1);
    step();
    a_m_tready = 1'b1;
    step();
    check("t4_drained", 32'(a_fill), 32'd0);
    a_m_tready = 1'b0;

    // reset mid-stream
    do_reset();
    for (int i = 0; i < 7; i++) begin
      a_s_tvalid = 1'b1; a_s_tdata = 8'(8'h40 + i); a_s_tlast = 1'b0;
      step();
    end
    a_s_tvalid = 1'b0;
    check("t5_level7", 32'(a_fill), 32'd7);
    rst = 1'b1;
    #1;
    check("t5_rst_tready", 32'(a_s_tready), 32'd0);
    step();
    rst = 1'b0;
    #1;
    check("t5_level",  32'(a_fill),     32'd0);
    check("t5_valid",  32'(a_m_tvalid), 32'd0);
    check("t5_aempty", 32'(a_ae),       32'd1);
    a_s_tvalid = 1'b1; a_s_tdata = 8'h77; a_s_tlast = 1'b1;
    step();
    a_s_tvalid = 1'b0; a_s_tlast = 1'b0;
    check("t5_next_valid", 32'(a_m_tvalid), 32'd1);
    check("t5_next_data",  32'(a_m_tdata),  32'h77);
    a_m_tready = 1'b1;
    step();
    check("t5_drained", 32'(a_fill), 32'd0);
    a_m_tready = 1'b0;

`ifdef AXIS_FIFO_PKT_MODE_EN
    // packet mode: hold until tlast, oversize release at full
    do_reset();
    for (int i = 0; i < 3; i++) begin
      a_s_tvalid = 1'b1; a_s_tdata = 8'(8'h60 + i); a_s_tlast = 1'b0;
      step();
    end
    check("p_hold_valid", 32'(a_m_tvalid), 32'd0);
    a_s_tdata = 8'h63; a_s_tlast = 1'b1;
    step();
    a_s_tvalid = 1'b0; a_s_tlast = 1'b0;
    check("p_frame_valid", 32'(a_m_tvalid), 32'd1);
    a_m_tready = 1'b1;
    repeat (4) step();
    check("p_frame_drained", 32'(a_fill), 32'd0);
    a_m_tready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      a_s_tvalid = 1'b1; a_s_tdata = 8'(8'h80 + i); a_s_tlast = 1'b0;
      step();
      if (i == 14) check("p_oversize_hold", 32'(a_m_tvalid), 32'd0);
    end
    a_s_tvalid = 1'b0;
    check("p_oversize_release", 32'(a_m_tvalid), 32'd1);
    a_m_tready = 1'b1;
    t = 0;
    while (a_fill != 0 && t < 40) begin step(); t++; end
    check("p_oversize_drained", 32'(a_fill), 32'd0);
    a_m_tready = 1'b0;
`endif

    // depth-5 randomised ordering
    do_reset();
    sent = 0; acc = 1'b0; rcv_b = 0;
    for (int c = 0; c < 20000 && sent < 1000; c++) begin
      if (!b_s_tvalid || acc) begin
        b_s_tvalid = ($urandom_range(0, 1) == 1);
        b_s_tdata  = 8'($urandom);
        b_s_tlast  = (sent == 999) || ($urandom_range(0, 3) == 0);
      end
      b_m_tready = ($urandom_range(0, 1) == 1);
      #1;
      acc = b_s_tvalid && b_s_tready;
      step();
      if (acc) sent++;
    end
    b_s_tvalid = 1'b0; b_s_tlast = 1'b0; b_m_tready = 1'b1;
    for (int c = 0; c < 200 && rcv_b < 1000; c++) step();
    check("b_sent",     32'(sent),   32'd1000);
    check("b_received", 32'(rcv_b),  32'd1000);
    check("b_empty",    32'(b_fill), 32'd0);
    b_m_tready = 1'b0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
